r_demux_m4: RTL and testbench
=============================

# r_demux_m4

Read-data return path for the 4-master AXI3 interconnect: takes the R channel of one slave port and routes each beat to one of four masters using the master index carried in `rid_s[5:4]`, which the AR path prefixes onto the ID (00=m1, 01=m2, 10=m3, 11=m4). The block strips the prefix, returns the original 4-bit ID, and decouples slave and master handshakes through a registered 2-entry skid buffer. One instance sits between each slave port and the four master ports.

## Interface
Parameters:
- `DW`, 32, data width of `rdata`.

Ports (every `_mN` port exists for N = 1..4):
- `aclk`  in  1  clock; all state updates on rising edge.
- `areset`  in  1  reset, synchronous, active-low.
- `rdata_s`  in  DW  slave read data.
- `rid_s`  in  6  slave read ID; [5:4] = master index, [3:0] = master's original ID.
- `rresp_s`  in  2  slave read response.
- `rlast_s`  in  1  last beat of burst.
- `rvalid_s`  in  1  slave beat valid.
- `rready_s`  out  1  block can accept a beat (registered).
- `rdata_mN`  out  DW  read data to master N.
- `rid_mN`  out  4  read ID to master N (prefix removed).
- `rresp_mN`  out  2  response to master N.
- `rlast_mN`  out  1  last beat to master N.
- `rvalid_mN`  out  1  beat valid to master N.
- `rready_mN`  in  1  master N accepts beat.

## Operation
- Storage: 2-entry FIFO, entry = {rdata, rid[5:0], rresp, rlast}; write pointer, read pointer (1 bit each), `count` 0..2.
- Push: `rvalid_s & rready_s` writes the slave beat at the write pointer; pointer toggles.
- Head: entry at the read pointer when `count != 0`. `sel` = head `rid[5:4]`.
- Routing: for the master selected by `sel`, `rvalid_mN = (count != 0)`, and `rdata/rresp/rlast_mN` come from the head with `rid_mN = head rid[3:0]`. All outputs of unselected masters are 0, and all master outputs are 0 when `count == 0`.
- Pop: `rvalid_mN & rready_mN` for the selected master; read pointer toggles. `rready` from unselected masters is ignored.
- `count_next = count + push - pop`. `rready_s` is a register loaded each cycle with `(count_next < 2)`.
- Ordering: beats leave in arrival order. A beat for one master blocks later beats for other masters until it is popped (head-of-line). Interleaving between bursts is whatever the slave issues; the block does no burst reassembly.
- `rresp` and `rlast` pass through unmodified. There is no error generation.

## Timing
- Reset (`areset` = 0 at an edge): `count`, both pointers = 0; `rready_s` = 0; all `rvalid_mN`, `rdata_mN`, `rid_mN`, `rresp_mN`, `rlast_mN` = 0. Reset mid-burst discards buffered beats without handshake.
- First edge after reset release: `rready_s` becomes 1.
- Latency: a beat accepted at edge T is visible on the master port in the cycle after T. There is no combinational path from slave inputs to master outputs, and none from `rready_mN` to `rready_s`.
- Throughput: 1 beat/cycle sustained when the destination holds `rready` high.
- Full (`count == 2`): `rready_s` = 0, so no push is possible. A pop in that cycle makes `rready_s` = 1 the next cycle.
- `count == 1` with simultaneous push and pop: `count` stays 1 and `rready_s` stays 1.
- Empty with a push: the beat is presented next cycle. Pop is impossible while empty.
- Master-side stability: while `rvalid_mN` = 1 and `rready_mN` = 0, all `_mN` outputs hold.
- Slave-side handshake: the slave may drop `rvalid_s` at any time; a beat counts only on `rvalid_s & rready_s`.

## Test plan
- Reset: hold `areset` = 0 for 3 cycles with `rvalid_s` = 1 -> `rready_s` = 0 and all master outputs 0; after release, `rready_s` = 1 at the next edge and nothing is pushed during reset.
- Routing/strip: beats with `rid_s` = 6'h05, 6'h1A, 6'h2F, 6'h33 and all `rready_mN` = 1 -> m1 gets id 5, m2 gets id A, m3 gets id F, m4 gets id 3, in that order, one cycle after each push, with the other masters' `rvalid` = 0.
- Streaming: a 16-beat burst to m2 (`rdata` = 0..15, `rlast` on beat 15) with `rready_m2` held 1 -> 16 consecutive `rvalid_m2` cycles, data 0..15, and `rlast_m2` only on the 16th beat.
- Backpressure: `rready_m3` = 0 while the slave sends 3 beats to m3 -> 2 beats are buffered and `rready_s` = 0 after the 2nd push; raise `rready_m3` -> the remaining beats drain in order with no loss or duplication.
- Head-of-line: a beat for m1 (`rready_m1` = 0) followed by a beat for m4 (`rready_m4` = 1) -> `rvalid_m4` stays 0 until m1 pops, then the m4 beat appears the next cycle.
- Reset mid-operation: `count` = 2, then `areset` = 0 for 1 cycle -> all `rvalid_mN` = 0 and the buffered beats are never delivered after release.

Source files
------------

// File: rtl/r_demux_m4.sv
// r_demux_m4
// ----------
// R-channel return demultiplexer for a 4-master AXI3 interconnect. One slave
// port's read beats are accepted into a registered 2-entry FIFO and routed
// to the master named by rid_s[5:4] (00=m1, 01=m2, 10=m3, 11=m4). The routing
// prefix is stripped so each master sees its original 4-bit ID.
//
// Handshake semantics (both sides): a beat transfers on a rising edge of
// aclk where valid & ready are both 1. A source holds its beat stable while
// valid is high and ready is low; ready never depends combinationally on
// valid of the same side.
//
// Ports:
//   aclk, areset            clock, synchronous active-low reset
//   rdata_s/rid_s/rresp_s/rlast_s/rvalid_s   slave R beat in
//   rready_s                registered accept to the slave
//   rdata_mN/rid_mN/rresp_mN/rlast_mN/rvalid_mN  beat out to master N
//   rready_mN               master N accepts beat (only the selected one counts)
module r_demux_m4 #(
    parameter int DW = 32
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic [DW-1:0] rdata_s,
    input  logic [5:0]    rid_s,
    input  logic [1:0]    rresp_s,
    input  logic          rlast_s,
    input  logic          rvalid_s,
    output logic          rready_s,
    output logic [DW-1:0] rdata_m1,
    output logic [3:0]    rid_m1,
    output logic [1:0]    rresp_m1,
    output logic          rlast_m1,
    output logic          rvalid_m1,
    input  logic          rready_m1,
    output logic [DW-1:0] rdata_m2,
    output logic [3:0]    rid_m2,
    output logic [1:0]    rresp_m2,
    output logic          rlast_m2,
    output logic          rvalid_m2,
    input  logic          rready_m2,
    output logic [DW-1:0] rdata_m3,
    output logic [3:0]    rid_m3,
    output logic [1:0]    rresp_m3,
    output logic          rlast_m3,
    output logic          rvalid_m3,
    input  logic          rready_m3,
    output logic [DW-1:0] rdata_m4,
    output logic [3:0]    rid_m4,
    output logic [1:0]    rresp_m4,
    output logic          rlast_m4,
    output logic          rvalid_m4,
    input  logic          rready_m4
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [5:0]    id;
        logic [1:0]    resp;
        logic          last;
    } beat_t;

    beat_t      mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       rready_s_q;
    logic       rready_s_d;

    beat_t      head;
    logic       not_empty;
    logic [1:0] sel;
    logic [3:0] rready_m;
    logic       push;
    logic       pop;

    logic [3:0]    rvalid_m;
    logic [DW-1:0] rdata_m [4];
    logic [3:0]    rid_m   [4];
    logic [1:0]    rresp_m [4];
    logic [3:0]    rlast_m;

    assign head      = mem_q[rd_ptr_q];
    assign not_empty = (count_q != 2'd0);
    assign sel       = head.id[5:4];
    assign rready_m  = {rready_m4, rready_m3, rready_m2, rready_m1};

    // Push uses the registered ready, so slave inputs never reach a master
    // output or rready_s in the same cycle.
    assign push = rvalid_s & rready_s_q;
    // Only the selected master's ready can pop the head.
    assign pop  = not_empty & rready_m[sel];

    always_comb begin
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        rready_s_d = (count_d < 2'd2);
    end

    // Route the head to the selected master; everything else reads as zero.
    always_comb begin
        rvalid_m = '0;
        rlast_m  = '0;
        for (int i = 0; i < 4; i++) begin
            rdata_m[i] = '0;
            rid_m[i]   = '0;
            rresp_m[i] = '0;
            if (not_empty && (sel == 2'(i))) begin
                rvalid_m[i] = 1'b1;
                rdata_m[i]  = head.data;
                rid_m[i]    = head.id[3:0];
                rresp_m[i]  = head.resp;
                rlast_m[i]  = head.last;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            rready_s_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q    <= count_d;
            rready_s_q <= rready_s_d;
        end
    end

    // Storage needs no reset: it is only observed while count_q != 0.
    always_ff @(posedge aclk) begin
        if (areset && push) begin
            mem_q[wr_ptr_q] <= '{data: rdata_s, id: rid_s, resp: rresp_s, last: rlast_s};
        end
    end

    assign rready_s = rready_s_q;

    assign rdata_m1  = rdata_m[0];
    assign rid_m1    = rid_m[0];
    assign rresp_m1  = rresp_m[0];
    assign rlast_m1  = rlast_m[0];
    assign rvalid_m1 = rvalid_m[0];

    assign rdata_m2  = rdata_m[1];
    assign rid_m2    = rid_m[1];
    assign rresp_m2  = rresp_m[1];
    assign rlast_m2  = rlast_m[1];
    assign rvalid_m2 = rvalid_m[1];

    assign rdata_m3  = rdata_m[2];
    assign rid_m3    = rid_m[2];
    assign rresp_m3  = rresp_m[2];
    assign rlast_m3  = rlast_m[2];
    assign rvalid_m3 = rvalid_m[2];

    assign rdata_m4  = rdata_m[3];
    assign rid_m4    = rid_m[3];
    assign rresp_m4  = rresp_m[3];
    assign rlast_m4  = rlast_m[3];
    assign rvalid_m4 = rvalid_m[3];

endmodule

// File: tb/tb_r_demux_m4.sv
// Directed testbench for r_demux_m4. Inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
module tb_r_demux_m4;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] rdata_s;
    logic [5:0]  rid_s;
    logic [1:0]  rresp_s;
    logic        rlast_s;
    logic        rvalid_s;
    logic        rready_s;
    logic [31:0] rdata_m1, rdata_m2, rdata_m3, rdata_m4;
    logic [3:0]  rid_m1, rid_m2, rid_m3, rid_m4;
    logic [1:0]  rresp_m1, rresp_m2, rresp_m3, rresp_m4;
    logic        rlast_m1, rlast_m2, rlast_m3, rlast_m4;
    logic        rvalid_m1, rvalid_m2, rvalid_m3, rvalid_m4;
    logic        rready_m1, rready_m2, rready_m3, rready_m4;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [31:0] dat [4];
    logic [3:0]  ids [4];
    logic [1:0]  rsp [4];

    assign vld    = {rvalid_m4, rvalid_m3, rvalid_m2, rvalid_m1};
    assign lst    = {rlast_m4, rlast_m3, rlast_m2, rlast_m1};
    assign dat[0] = rdata_m1;
    assign dat[1] = rdata_m2;
    assign dat[2] = rdata_m3;
    assign dat[3] = rdata_m4;
    assign ids[0] = rid_m1;
    assign ids[1] = rid_m2;
    assign ids[2] = rid_m3;
    assign ids[3] = rid_m4;
    assign rsp[0] = rresp_m1;
    assign rsp[1] = rresp_m2;
    assign rsp[2] = rresp_m3;
    assign rsp[3] = rresp_m4;

    always #5 aclk = ~aclk;

    r_demux_m4 #(.DW(32)) dut (
        .aclk(aclk), .areset(areset),
        .rdata_s(rdata_s), .rid_s(rid_s), .rresp_s(rresp_s),
        .rlast_s(rlast_s), .rvalid_s(rvalid_s), .rready_s(rready_s),
        .rdata_m1(rdata_m1), .rid_m1(rid_m1), .rresp_m1(rresp_m1),
        .rlast_m1(rlast_m1), .rvalid_m1(rvalid_m1), .rready_m1(rready_m1),
        .rdata_m2(rdata_m2), .rid_m2(rid_m2), .rresp_m2(rresp_m2),
        .rlast_m2(rlast_m2), .rvalid_m2(rvalid_m2), .rready_m2(rready_m2),
        .rdata_m3(rdata_m3), .rid_m3(rid_m3), .rresp_m3(rresp_m3),
        .rlast_m3(rlast_m3), .rvalid_m3(rvalid_m3), .rready_m3(rready_m3),
        .rdata_m4(rdata_m4), .rid_m4(rid_m4), .rresp_m4(rresp_m4),
        .rlast_m4(rlast_m4), .rvalid_m4(rvalid_m4), .rready_m4(rready_m4)
    );

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic drive_beat(input logic [5:0] id, input logic [31:0] d,
                              input logic [1:0] r, input logic l);
        rvalid_s = 1'b1;
        rid_s    = id;
        rdata_s  = d;
        rresp_s  = r;
        rlast_s  = l;
    endtask

    task automatic test_reset();
        areset = 1'b0;
        drive_beat(6'h05, 32'hDEAD_BEEF, 2'b01, 1'b1);
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (rready_s !== 1'b0 || vld !== 4'h0 || lst !== 4'h0 ||
                dat[0] !== 32'h0 || ids[0] !== 4'h0 || rsp[0] !== 2'h0) begin
                failures++;
                $display("FAIL reset_hold c=%0d rready_s=%b vld=%b lst=%b d1=%h id1=%h r1=%h want 0",
                         c, rready_s, vld, lst, dat[0], ids[0], rsp[0]);
            end
        end
        areset   = 1'b1;
        rvalid_s = 1'b0;
        step();
        checks++;
        if (rready_s !== 1'b1 || vld !== 4'h0) begin
            failures++;
            $display("FAIL reset_release rready_s=%b vld=%b want rready_s=1 vld=0000", rready_s, vld);
        end
    endtask

    task automatic test_routing();
        logic [5:0]  in_id  [4] = '{6'h05, 6'h1A, 6'h2F, 6'h33};
        logic [3:0]  exp_id [4] = '{4'h5, 4'hA, 4'hF, 4'h3};
        logic [3:0]  exp_v  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'hF;
        for (int i = 0; i < 4; i++) begin
            drive_beat(in_id[i], 32'hA000_0000 + 32'(i), 2'(i), i[0]);
            step();
            checks++;
            if (vld !== exp_v[i] || ids[i] !== exp_id[i] || dat[i] !== 32'hA000_0000 + 32'(i) ||
                rsp[i] !== 2'(i) || lst[i] !== i[0]) begin
                failures++;
                $display("FAIL routing beat=%0d vld=%b id=%h data=%h resp=%h last=%b want vld=%b id=%h data=%h resp=%h last=%b",
                         i, vld, ids[i], dat[i], rsp[i], lst[i], exp_v[i], exp_id[i],
                         32'hA000_0000 + 32'(i), 2'(i), i[0]);
            end
            for (int j = 0; j < 4; j++) begin
                if (j != i) begin
                    checks++;
                    if (dat[j] !== 32'h0 || ids[j] !== 4'h0 || rsp[j] !== 2'h0) begin
                        failures++;
                        $display("FAIL routing_unsel beat=%0d m=%0d data=%h id=%h resp=%h want 0",
                                 i, j + 1, dat[j], ids[j], rsp[j]);
                    end
                end
            end
        end
        rvalid_s = 1'b0;
        step();
        checks++;
        if (vld !== 4'h0) begin
            failures++;
            $display("FAIL routing_drain vld=%b want 0000", vld);
        end
    endtask

    task automatic test_streaming();
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            drive_beat(6'h17, 32'(i), 2'b00, (i == 15));
            step();
            checks++;
            if (vld !== 4'b0010 || dat[1] !== 32'(i) || ids[1] !== 4'h7 || lst[1] !== (i == 15)) begin
                failures++;
                $display("FAIL stream beat=%0d vld=%b data=%h id=%h last=%b want vld=0010 data=%h id=7 last=%b",
                         i, vld, dat[1], ids[1], lst[1], 32'(i), (i == 15));
            end
        end
        rvalid_s = 1'b0;
        step();
        checks++;
        if (vld !== 4'h0 || rready_s !== 1'b1) begin
            failures++;
            $display("FAIL stream_end vld=%b rready_s=%b want 0000/1", vld, rready_s);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d   [5] = '{32'd100, 32'd100, 32'd100, 32'd101, 32'd102};
        logic        exp_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'b1011;
        for (int i = 0; i < 5; i++) begin
            // Slave offers beats 100,101,102; 102 waits while the buffer is full.
            if (i < 3) drive_beat(6'h2C, 32'd100 + 32'(i), 2'b10, (i == 2));
            if (i == 3) {rready_m4, rready_m3, rready_m2, rready_m1} = 4'hF;
            step();
            checks++;
            if (vld !== 4'b0100 || dat[2] !== exp_d[i] || ids[2] !== 4'hC || rready_s !== exp_rdy[i]) begin
                failures++;
                $display("FAIL backpressure step=%0d vld=%b data=%0d id=%h rready_s=%b want vld=0100 data=%0d id=c rready_s=%b",
                         i, vld, dat[2], ids[2], rready_s, exp_d[i], exp_rdy[i]);
            end
        end
        rvalid_s = 1'b0;
        step();
        checks++;
        if (vld !== 4'h0 || rready_s !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_drain vld=%b rready_s=%b want 0000/1", vld, rready_s);
        end
    endtask

    task automatic test_head_of_line();
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'b1000;
        drive_beat(6'h01, 32'd200, 2'b00, 1'b1);
        step();
        drive_beat(6'h3E, 32'd201, 2'b11, 1'b1);
        step();
        rvalid_s = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (vld !== 4'b0001 || dat[0] !== 32'd200 || ids[0] !== 4'h1 || rready_s !== 1'b0) begin
                failures++;
                $display("FAIL hol_block c=%0d vld=%b data=%0d id=%h rready_s=%b want vld=0001 data=200 id=1 rready_s=0",
                         c, vld, dat[0], ids[0], rready_s);
            end
            step();
        end
        rready_m1 = 1'b1;
        step();
        checks++;
        if (vld !== 4'b1000 || dat[3] !== 32'd201 || ids[3] !== 4'hE || rsp[3] !== 2'b11) begin
            failures++;
            $display("FAIL hol_release vld=%b data=%0d id=%h resp=%h want vld=1000 data=201 id=e resp=3",
                     vld, dat[3], ids[3], rsp[3]);
        end
        step();
        checks++;
        if (vld !== 4'h0) begin
            failures++;
            $display("FAIL hol_drain vld=%b want 0000", vld);
        end
    endtask

    task automatic test_mid_reset();
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'h0;
        drive_beat(6'h19, 32'd300, 2'b00, 1'b0);
        step();
        drive_beat(6'h19, 32'd301, 2'b00, 1'b1);
        step();
        rvalid_s = 1'b0;
        checks++;
        if (vld !== 4'b0010 || rready_s !== 1'b0 || dat[1] !== 32'd300) begin
            failures++;
            $display("FAIL midrst_full vld=%b rready_s=%b data=%0d want 0010/0/300", vld, rready_s, dat[1]);
        end
        areset = 1'b0;
        step();
        checks++;
        if (vld !== 4'h0 || rready_s !== 1'b0 || dat[1] !== 32'h0 || lst !== 4'h0) begin
            failures++;
            $display("FAIL midrst_assert vld=%b rready_s=%b data=%h lst=%b want all 0", vld, rready_s, dat[1], lst);
        end
        areset = 1'b1;
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'hF;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (vld !== 4'h0 || rready_s !== 1'b1) begin
                failures++;
                $display("FAIL midrst_after c=%0d vld=%b rready_s=%b want 0000/1", c, vld, rready_s);
            end
        end
    endtask

    initial begin
        areset   = 1'b0;
        rvalid_s = 1'b0;
        rdata_s  = '0;
        rid_s    = '0;
        rresp_s  = '0;
        rlast_s  = 1'b0;
        {rready_m4, rready_m3, rready_m2, rready_m1} = 4'h0;
        @(negedge aclk);
        test_reset();
        test_routing();
        test_streaming();
        test_backpressure();
        test_head_of_line();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
